// File: rtl/vrf_load_unit.sv
// vrf_load_unit: fetches 4 bytes from memory and writes them as one 32b vector into the VRF; ports: clk/rst_n, start/vreg_dst/base_addr/abort in, busy/done out, mem_* read port, vregw/vdataw/vrf_write VRF port
module vrf_load_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        vreg_dst_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [1:0]        vregw_o,
  output logic [31:0]       vdataw_o,
  output logic              vrf_write_o
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t            state_q;
  logic [1:0]        lane_q, vreg_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       buf_q, buf_d;
  always_comb begin
    buf_d = buf_q;
    buf_d[{lane_q, 3'b000} +: 8] = mem_rdata_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      vreg_q      <= '0;
      base_q      <= '0;
      buf_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_addr_o  <= '0;
      mem_rd_o    <= 1'b0;
      vregw_o     <= '0;
      vdataw_o    <= '0;
      vrf_write_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q    <= READ;
          vreg_q     <= vreg_dst_i;
          base_q     <= base_addr_i;
          lane_q     <= '0;
          mem_rd_o   <= 1'b1;
          mem_addr_o <= base_addr_i;
          busy_o     <= 1'b1;
        end
        READ: if (abort_i) begin
          state_q  <= IDLE;
          mem_rd_o <= 1'b0;
          busy_o   <= 1'b0;
        end else if (mem_ready_i) begin
          buf_q      <= buf_d;
          lane_q     <= lane_q + 2'd1;
          mem_addr_o <= base_q + ADDR_W'(lane_q) + ADDR_W'(1);
          if (lane_q == 2'd3) begin
            state_q     <= WRITE;
            mem_rd_o    <= 1'b0;
            vrf_write_o <= 1'b1;
            done_o      <= 1'b1;
            vregw_o     <= vreg_q;
            vdataw_o    <= buf_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          vrf_write_o <= 1'b0;
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vrf_load_unit.sv
// tb_vrf_load_unit: directed checks of vrf_load_unit against a transaction-level model
module tb_vrf_load_unit;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, mem_ready = 0;
  logic [1:0]  vreg_dst = 0, vregw;
  logic [7:0]  base_addr = 0, mem_addr, mem_rdata;
  logic        busy, done, mem_rd, vrf_write;
  logic [31:0] vdataw;
  logic [7:0]  mem [256];
  int cmp = 0, bad = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  vrf_load_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .vreg_dst_i(vreg_dst),
    .base_addr_i(base_addr), .abort_i(abort), .busy_o(busy), .done_o(done),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .vregw_o(vregw), .vdataw_o(vdataw), .vrf_write_o(vrf_write)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: -1 idle, 0..3 = lane awaited, 4 = write cycle
  int         m_ph = -1;
  logic [7:0] m_base = 0;
  logic [1:0] m_vreg = 0;
  logic [1:0] m_vregw = 0;
  logic [31:0] m_data = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = -1; m_base = 0; m_vreg = 0; m_vregw = 0; m_data = 0;
    end else if (m_ph == -1) begin
      if (start) begin m_ph = 0; m_base = base_addr; m_vreg = vreg_dst; end
    end else if (m_ph == 4) m_ph = -1;
    else if (abort) m_ph = -1;
    else if (mem_ready) begin
      m_ph++;
      if (m_ph == 4) begin
        m_vregw = m_vreg;
        m_data = {mem[8'(m_base + 3)], mem[8'(m_base + 2)], mem[8'(m_base + 1)], mem[m_base]};
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    check("busy", 32'(busy), 32'(m_ph >= 0));
    check("mem_rd", 32'(mem_rd), 32'(m_ph >= 0 && m_ph < 4));
    check("vrf_write", 32'(vrf_write), 32'(m_ph == 4));
    check("done", 32'(done), 32'(m_ph == 4));
    check("vregw", 32'(vregw), 32'(m_vregw));
    check("vdataw", vdataw, m_data);
    if (m_ph >= 0 && m_ph < 4) check("mem_addr", 32'(mem_addr), 32'(8'(m_base + 8'(m_ph))));
  end
  // one load: cycle i (1-based) drives mem_ready/abort for edge Ei after the start edge E0
  task automatic run_load(input logic [1:0] dst, input logic [7:0] base, input bit stall,
                          input int ab_i, input int ss_i,
                          output int n, output int nw, output logic [31:0] wv, output logic [1:0] wr);
    n = 0; nw = 0; wv = 0; wr = 0;
    start = 1; vreg_dst = dst; base_addr = base;
    @(posedge clk); #2;
    start = 0;
    for (int i = 1; i <= 12; i++) begin
      mem_ready = !(stall && i >= 2 && i <= 4);
      abort = (i == ab_i);
      if (i == ss_i) begin start = 1; vreg_dst = 2'd3; base_addr = 8'h80; end
      else start = 0;
      @(negedge clk);
      if (vrf_write) begin nw++; if (n == 0) begin n = i; wv = vdataw; wr = vregw; end end
      @(posedge clk); #2;
    end
    mem_ready = 0; abort = 0; start = 0;
  endtask
  int n, nw;
  logic [31:0] wv;
  logic [1:0] wr;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst mem_rd", 32'(mem_rd), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst vdataw", vdataw, 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #2;
    run_load(2'd2, 8'h10, 0, 0, 0, n, nw, wv, wr);
    check("basic latency", 32'(n), 5);
    check("basic writes", 32'(nw), 1);
    check("basic data", wv, 32'h44332211);
    check("basic vreg", 32'(wr), 2);
    run_load(2'd2, 8'h10, 1, 0, 0, n, nw, wv, wr);
    check("stall latency", 32'(n), 8);
    check("stall data", wv, 32'h44332211);
    run_load(2'd0, 8'hFE, 0, 0, 0, n, nw, wv, wr);
    check("wrap data", wv, 32'hDDCCBBAA);
    check("wrap writes", 32'(nw), 1);
    run_load(2'd2, 8'h10, 0, 3, 0, n, nw, wv, wr);
    check("abort writes", 32'(nw), 0);
    check("abort busy", 32'(busy), 0);
    run_load(2'd1, 8'h10, 0, 0, 0, n, nw, wv, wr);
    check("post-abort data", wv, 32'h44332211);
    check("post-abort vreg", 32'(wr), 1);
    run_load(2'd2, 8'h20, 0, 0, 2, n, nw, wv, wr);
    check("busy-start writes", 32'(nw), 1);
    check("busy-start vreg", 32'(wr), 2);
    check("busy-start data", wv, 32'h04030201);
    start = 1; vreg_dst = 2'd3; base_addr = 8'h10; mem_ready = 1;
    @(posedge clk); #2 start = 0;
    @(posedge clk); #3 rst_n = 0;
    #1;
    check("async busy", 32'(busy), 0);
    check("async mem_rd", 32'(mem_rd), 0);
    check("async write", 32'(vrf_write), 0);
    check("async done", 32'(done), 0);
    @(posedge clk); #2 rst_n = 1;
    nw = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (vrf_write) nw++; end
    check("post-reset writes", 32'(nw), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/vrf_load_unit.md
Name: vrf_load_unit

Overview:
- Vector load sequencer that fills one vector register from byte-wide data memory.
- On a start command it fetches 4 consecutive bytes, one per memory handshake, and packs them into a 4x8b vector.
- It then issues one write on the vector register file write port (vregw, vdataw, VRFWrite).
- Sits between the processor control FSM (start/done), the data memory read port, and the VRF write port.

Parameters:
- ADDR_W, 8: memory address width. Lane addresses wrap modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  load request, sampled in IDLE only
- vreg_dst  in  2  destination vector register, captured with start
- base_addr  in  ADDR_W  address of lane 0, captured with start
- abort  in  1  synchronous cancel of an in-flight load
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with VRFWrite
- mem_addr  out  ADDR_W  current byte address
- mem_rd  out  1  memory read request
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  memory handshake; a byte transfers on an edge where mem_rd=1 and mem_ready=1
- vregw  out  2  VRF write register number
- vdataw  out  32  VRF write data
- VRFWrite  out  1  VRF write enable, one cycle

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, lane counter=0, assembly buffer=0.
  - busy=0, done=0, mem_rd=0, mem_addr=0, vregw=0, vdataw=0, VRFWrite=0.
  - Reset asserted mid-load discards the load; no VRF write occurs.
- States: IDLE, READ, WRITE.
- IDLE:
  - On an edge with start=1, capture vreg_dst and base_addr, clear the lane counter, go to READ.
  - In the same edge drive mem_rd=1, mem_addr=base_addr, busy=1.
- READ:
  - mem_rd stays 1 and mem_addr = base_addr + lane (mod 2^ADDR_W) until a handshake.
  - On an edge with mem_ready=1: buffer[8*lane+7 : 8*lane] <= mem_rdata, and lane increments.
  - mem_addr updates to the next lane on that same edge.
  - On the handshake for lane 3: go to WRITE, mem_rd <= 0, VRFWrite <= 1, done <= 1, vregw <= captured vreg_dst, vdataw <= full assembled word including lane 3's byte.
  - mem_ready=0 holds state indefinitely (no timeout).
- WRITE:
  - Lasts exactly one cycle with VRFWrite=1 and done=1.
  - Next edge: VRFWrite=0, done=0, busy=0, state=IDLE.
  - vdataw and vregw hold their last values until the next load.
- Lane packing: lane i = byte at base_addr+i, placed in bits [8i+7:8i] (little-endian).
- Latency with mem_ready tied high:
  - start sampled at edge E0; lanes 0..3 transfer at E1..E4.
  - VRFWrite/done high in the cycle after E4; busy high from after E0 through the VRFWrite cycle.
  - Start-to-start pitch is 6 cycles: start is accepted again at E5 is not possible, since the unit is in WRITE then; the earliest accept is E6.
- start while busy: ignored; no queuing, and captured values do not change.
- abort:
  - In READ: return to IDLE on that edge, mem_rd=0, busy=0, no VRF write, done=0.
  - In IDLE or WRITE: no effect. The WRITE cycle always completes.
  - abort and mem_ready both high on the lane-3 edge: abort wins, no write.
  - abort and start together in IDLE: start is accepted.
- Address wrap: base_addr=2^ADDR_W-2 fetches lanes at FE, FF, 00, 01 (ADDR_W=8).
- mem_ready seen while mem_rd=0 is ignored.

Test Plan:
- Basic load:
  - Stimulus: reset 0→1; start with vreg_dst=2, base_addr=0x10; mem_ready=1; memory[0x10..0x13]=0x11,0x22,0x33,0x44.
  - Required: mem_addr sequence 0x10..0x13; VRFWrite=1 for exactly one cycle, 5 cycles after start, with vregw=2, vdataw=0x44332211; done pulses with it; busy falls on the next edge.
- Stalled memory:
  - Stimulus: same load, with mem_ready=0 for 3 cycles before lane 1.
  - Required: mem_addr holds 0x11 and mem_rd holds 1 through the stall; write occurs 8 cycles after start with the same vdataw.
- Address wrap:
  - Stimulus: base_addr=0xFE; bytes 0xAA,0xBB,0xCC,0xDD.
  - Required: mem_addr sequence FE, FF, 00, 01; vdataw=0xDDCCBBAA.
- Abort:
  - Stimulus: abort=1 on the lane-2 handshake edge.
  - Required: busy=0 and mem_rd=0 the next cycle; VRFWrite never asserts; a following start with vreg_dst=1 loads correctly.
- Start while busy:
  - Stimulus: a second start with vreg_dst=3, base_addr=0x80 during READ.
  - Required: ignored; the write still targets the original vreg_dst with the original data.
- Async reset:
  - Stimulus: reset=0 mid-READ, asserted between clock edges.
  - Required: busy, mem_rd, VRFWrite and done drop to 0 before the next edge; no write after reset is released.
